// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the C2F chunk consumer: pointer/offset typedefs, checksum
// mode and consumer FSM state encodings.
package tlp_xcvr_pkg;

  localparam int C2F_PTR_WIDTH    = 2;
  localparam int C2F_OFFSET_WIDTH = 4;

  typedef logic [C2F_PTR_WIDTH-1:0]    C2FChunkPtr;
  typedef logic [C2F_OFFSET_WIDTH-1:0] C2FChunkOffset;
  typedef logic [31:0]                 uint32;
  typedef logic [63:0]                 uint64;

  typedef enum logic {
    CK_ADD = 1'b0,
    CK_XOR = 1'b1
  } CkMode;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4
  } ConsumerState;

  // A chunk can never be acknowledged before its last word has landed.
  function automatic uint32 dwellCycles(input uint32 countInit, input uint32 minCycles);
    return (countInit > minCycles) ? countInit : minCycles;
  endfunction

endpackage

// File: rtl/c2f_ck_accum.sv
// Checksum accumulator: read-valid tag pipeline, ADD/XOR mode mux and the
// checksum register with clear taking priority over accumulation.
module c2f_ck_accum
  import tlp_xcvr_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                  sysClk_in,
  input  logic                  sysRst_in,
  input  logic                  issue_in,
  input  CkMode                 mode_in,
  input  logic                  clear_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] ck_out,
  output logic                  lastWord_out
);

  // Only the oldest tag set means the final in-flight word is landing now.
  localparam logic [RD_LATENCY-1:0] OLDEST_ONLY = RD_LATENCY'(1) << (RD_LATENCY - 1);

  logic [RD_LATENCY-1:0] tagQ;
  logic [RD_LATENCY-1:0] tagNext;
  logic [DATA_WIDTH-1:0] ckQ;
  logic [DATA_WIDTH-1:0] ckNext;
  logic                  accumEn;

  assign accumEn      = tagQ[RD_LATENCY-1];
  assign lastWord_out = (tagQ == OLDEST_ONLY);
  assign ck_out       = ckQ;

  always_comb begin
    tagNext    = tagQ << 1;
    tagNext[0] = issue_in;
  end

  always_comb begin
    ckNext = ckQ;
    if (clear_in) begin
      ckNext = '0;
    end else if (accumEn) begin
      if (mode_in == CK_XOR) ckNext = ckQ ^ data_in;
      else                   ckNext = ckQ + data_in;
    end
  end

  always_ff @(posedge sysClk_in) begin
    if (sysRst_in) begin
      tagQ <= '0;
      ckQ  <= '0;
    end else begin
      tagQ <= tagNext;
      ckQ  <= ckNext;
    end
  end

endmodule

// File: rtl/c2f_chunk_consumer.sv
// C2F chunk consumer: drains one chunk per ring slot, checksums it, holds it
// for a dwell time and acks it. Optional stats ports under C2F_CONSUMER_STATS_EN.
module c2f_chunk_consumer
  import tlp_xcvr_pkg::*;
#(
  parameter int PTR_WIDTH    = 2,
  parameter int OFFSET_WIDTH = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int RD_LATENCY   = 1
) (
  input  logic                    sysClk_in,
  input  logic                    sysRst_in,
  input  logic [PTR_WIDTH-1:0]    wrPtr_in,
  input  logic [PTR_WIDTH-1:0]    rdPtr_in,
  output logic                    dtAck_out,
  output logic [OFFSET_WIDTH-1:0] rdOffset_out,
  input  logic [DATA_WIDTH-1:0]   rdData_in,
  input  logic                    mode_in,
  output logic [DATA_WIDTH-1:0]   csData_out,
  output logic                    csValid_out,
  input  logic                    csReset_in,
  input  logic [31:0]             countInit_in,
  output logic                    busy_out,
  output ConsumerState            dbgState_out
`ifdef C2F_CONSUMER_STATS_EN
  ,
  output logic [31:0]             chunkCount_out,
  output logic [31:0]             stallCount_out
`endif
);

  localparam int                    N           = 1 << OFFSET_WIDTH;
  localparam logic [OFFSET_WIDTH-1:0] LAST_OFFSET = OFFSET_WIDTH'(N - 1);
  localparam uint32                 MIN_DWELL   = 32'(N + RD_LATENCY);

  ConsumerState             stateQ;
  ConsumerState             stateNext;
  logic [OFFSET_WIDTH-1:0]  offsetQ;
  logic [OFFSET_WIDTH-1:0]  offsetNext;
  uint32                    remainQ;
  uint32                    remainNext;
  CkMode                    modeQ;
  logic                     holdoffQ;
  logic                     start;
  logic                     issue;
  logic                     lastWord;

  // Handshake: dtAck_out pulses once per consumed chunk; the ring logic answers
  // by advancing rdPtr_in, and the one-cycle holdoff after ACK gives it time.
  assign start = (stateQ == S_IDLE) && (countInit_in != 32'd0) &&
                 (wrPtr_in != rdPtr_in) && !holdoffQ;
  assign issue = start || (stateQ == S_READ);

  assign csValid_out  = (wrPtr_in == rdPtr_in) && (stateQ == S_IDLE);
  assign busy_out     = (stateQ != S_IDLE);
  assign dbgState_out = stateQ;

  // remainQ counts down to the ack cycle; it equals D - j in cycle T0 + j.
  always_comb begin
    stateNext    = stateQ;
    offsetNext   = offsetQ;
    remainNext   = remainQ;
    dtAck_out    = 1'b0;
    rdOffset_out = offsetQ;
    case (stateQ)
      S_IDLE: begin
        if (start) begin
          rdOffset_out = '0;
          offsetNext   = OFFSET_WIDTH'(1);
          remainNext   = dwellCycles(countInit_in, MIN_DWELL) - 32'd1;
          stateNext    = S_READ;
        end
      end
      S_READ: begin
        remainNext = remainQ - 32'd1;
        if (offsetQ == LAST_OFFSET) stateNext  = S_DRAIN;
        else                        offsetNext = offsetQ + OFFSET_WIDTH'(1);
      end
      S_DRAIN: begin
        remainNext = remainQ - 32'd1;
        if (lastWord) stateNext = (remainQ == 32'd1) ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        remainNext = remainQ - 32'd1;
        if (remainQ == 32'd1) stateNext = S_ACK;
      end
      S_ACK: begin
        dtAck_out = 1'b1;
        stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge sysClk_in) begin
    if (sysRst_in) begin
      stateQ   <= S_IDLE;
      offsetQ  <= '0;
      remainQ  <= '0;
      modeQ    <= CK_ADD;
      holdoffQ <= 1'b0;
    end else begin
      stateQ   <= stateNext;
      offsetQ  <= offsetNext;
      remainQ  <= remainNext;
      holdoffQ <= (stateQ == S_ACK);
      if (start) modeQ <= CkMode'(mode_in);
    end
  end

  c2f_ck_accum #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_accum (
    .sysClk_in    (sysClk_in),
    .sysRst_in    (sysRst_in),
    .issue_in     (issue),
    .mode_in      (modeQ),
    .clear_in     (csReset_in),
    .data_in      (rdData_in),
    .ck_out       (csData_out),
    .lastWord_out (lastWord)
  );

`ifdef C2F_CONSUMER_STATS_EN
  uint32 chunkCountQ;
  uint32 stallCountQ;
  logic  stalled;

  assign stalled        = (stateQ == S_IDLE) && (wrPtr_in != rdPtr_in) && (countInit_in == 32'd0);
  assign chunkCount_out = chunkCountQ;
  assign stallCount_out = stallCountQ;

  always_ff @(posedge sysClk_in) begin
    if (sysRst_in) begin
      chunkCountQ <= '0;
      stallCountQ <= '0;
    end else begin
      if (dtAck_out && (chunkCountQ != 32'hFFFF_FFFF)) chunkCountQ <= chunkCountQ + 32'd1;
      if (stalled && (stallCountQ != 32'hFFFF_FFFF))   stallCountQ <= stallCountQ + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_c2f_chunk_consumer.sv
// Bench for c2f_chunk_consumer: two instances (read latency 1 and 3) share
// stimulus; a scoreboard pairs each dtAck_out with its expected cycle/checksum.
`timescale 1ns/1ps
module tb_c2f_chunk_consumer;
  import tlp_xcvr_pkg::*;

  localparam int PW = 2;
  localparam int OW = 3;
  localparam int DW = 64;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_rst;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr0 = '0;
  logic [PW-1:0] rd_ptr1 = '0;
  logic          mode;
  logic          cs_reset;
  logic [31:0]   count_init;

  logic          dt_ack0, dt_ack1;
  logic [OW-1:0] rd_off0, rd_off1;
  logic [DW-1:0] rd_data0, rd_data1;
  logic [DW-1:0] cs0, cs1;
  logic          cs_valid0, cs_valid1, busy0, busy1;
  ConsumerState  st0, st1;
`ifdef C2F_CONSUMER_STATS_EN
  logic [31:0]   chunk_cnt0, chunk_cnt1, stall_cnt0, stall_cnt1;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] pipe0, pipe1a, pipe1b, pipe1c;
  logic [DW-1:0] exp_ck0[$];
  logic [DW-1:0] exp_ck1[$];
  int            exp_cyc0[$];
  int            exp_cyc1[$];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: registered read, then extra pipe stages for latency 3
  always @(posedge clk) begin
    pipe0  <= mem[rd_off0];
    pipe1a <= mem[rd_off1];
    pipe1b <= pipe1a;
    pipe1c <= pipe1b;
  end
  assign rd_data0 = pipe0;
  assign rd_data1 = pipe1c;

  c2f_chunk_consumer #(.PTR_WIDTH(PW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut0 (
    .sysClk_in(clk), .sysRst_in(sys_rst), .wrPtr_in(wr_ptr), .rdPtr_in(rd_ptr0),
    .dtAck_out(dt_ack0), .rdOffset_out(rd_off0), .rdData_in(rd_data0), .mode_in(mode),
    .csData_out(cs0), .csValid_out(cs_valid0), .csReset_in(cs_reset),
    .countInit_in(count_init), .busy_out(busy0), .dbgState_out(st0)
`ifdef C2F_CONSUMER_STATS_EN
    , .chunkCount_out(chunk_cnt0), .stallCount_out(stall_cnt0)
`endif
  );

  c2f_chunk_consumer #(.PTR_WIDTH(PW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut1 (
    .sysClk_in(clk), .sysRst_in(sys_rst), .wrPtr_in(wr_ptr), .rdPtr_in(rd_ptr1),
    .dtAck_out(dt_ack1), .rdOffset_out(rd_off1), .rdData_in(rd_data1), .mode_in(mode),
    .csData_out(cs1), .csValid_out(cs_valid1), .csReset_in(cs_reset),
    .countInit_in(count_init), .busy_out(busy1), .dbgState_out(st1)
`ifdef C2F_CONSUMER_STATS_EN
    , .chunkCount_out(chunk_cnt1), .stallCount_out(stall_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every ack must match the oldest expected chunk; ring logic advances rdPtr
  always @(negedge clk) begin
    if (!sys_rst && dt_ack0) begin
      if (exp_ck0.size() == 0) begin
        check("ack0_unexpected", 64'd1, 64'd0);
      end else begin
        check("ack0_cycle", 64'(cyc), 64'(exp_cyc0.pop_front()));
        check("ack0_csum", cs0, exp_ck0.pop_front());
      end
      rd_ptr0 = rd_ptr0 + 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!sys_rst && dt_ack1) begin
      if (exp_ck1.size() == 0) begin
        check("ack1_unexpected", 64'd1, 64'd0);
      end else begin
        check("ack1_cycle", 64'(cyc), 64'(exp_cyc1.pop_front()));
        check("ack1_csum", cs1, exp_ck1.pop_front());
      end
      rd_ptr1 = rd_ptr1 + 1'b1;
    end
  end

  // driver tasks (all return #1 after a rising edge)
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_seq_words();
    for (int i = 0; i < 8; i++) mem[i] = 64'(i + 1);
  endtask

  task automatic clear_cs();
    cs_reset = 1'b1;
    tick(1);
    cs_reset = 1'b0;
    @(negedge clk);
    check("clear_cs0", cs0, 64'd0);
    check("clear_cs1", cs1, 64'd0);
    tick(1);
  endtask

  task automatic start_chunk(input int ci, input logic m, input logic [PW-1:0] wr,
                             input logic [DW-1:0] ck, input bit push);
    int t0;
    count_init = 32'(ci);
    mode       = m;
    wr_ptr     = wr;
    t0         = cyc;
    if (push) begin
      exp_ck0.push_back(ck);
      exp_ck1.push_back(ck);
      exp_cyc0.push_back(t0 + ((ci > 9) ? ci : 9));
      exp_cyc1.push_back(t0 + ((ci > 11) ? ci : 11));
    end
  endtask

  task automatic wait_acks();
    int budget = 0;
    while ((exp_ck0.size() != 0 || exp_ck1.size() != 0) && budget < 80) begin
      @(posedge clk);
      budget++;
    end
    check("ack_timeout", 64'(exp_ck0.size() + exp_ck1.size()), 64'd0);
    #1;
    tick(2);
  endtask

  task automatic check_idle_valid(input string tag, input logic exp_valid);
    @(negedge clk);
    check({tag, "_valid0"}, 64'(cs_valid0), 64'(exp_valid));
    check({tag, "_valid1"}, 64'(cs_valid1), 64'(exp_valid));
    check({tag, "_busy0"}, 64'(busy0), 64'd0);
    check({tag, "_busy1"}, 64'(busy1), 64'd0);
    tick(1);
  endtask

  initial begin
    int t_stall;
    sys_rst    = 1'b1;
    wr_ptr     = '0;
    mode       = 1'b0;
    cs_reset   = 1'b0;
    count_init = 32'd20;
    load_seq_words();
    tick(3);
    sys_rst = 1'b0;

    @(negedge clk);
    check("rst_ack0", 64'(dt_ack0), 64'd0);
    check("rst_off0", 64'(rd_off0), 64'd0);
    check("rst_cs0", cs0, 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_valid0", 64'(cs_valid0), 64'd1);
    check("rst_state0", 64'(st0), 64'(S_IDLE));
    check("rst_cs1", cs1, 64'd0);
    check("rst_valid1", 64'(cs_valid1), 64'd1);
    tick(1);

    // 1: common setup, offsets 0..7 from T0, ack at T0+20, checksum 36
    start_chunk(20, 1'b0, 2'd1, 64'd36, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t1_off0", 64'(rd_off0), 64'(k));
      check("t1_off1", 64'(rd_off1), 64'(k));
    end
    wait_acks();
    check_idle_valid("t1", 1'b1);

    // 2: dwell shorter than N+L clamps to N+L
    clear_cs();
    start_chunk(3, 1'b0, 2'd2, 64'd36, 1'b1);
    wait_acks();
    check_idle_valid("t2", 1'b1);

    // 3: XOR mode, then a checksum clear
    clear_cs();
    mem[0] = 64'hFF;
    mem[1] = 64'h0F;
    for (int i = 2; i < 8; i++) mem[i] = '0;
    start_chunk(20, 1'b1, 2'd3, 64'hF0, 1'b1);
    wait_acks();
    clear_cs();

    // 4: ADD wraps; write pointer wraps to 0
    for (int i = 0; i < 8; i++) mem[i] = '1;
    start_chunk(20, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
    wait_acks();
    check_idle_valid("t4", 1'b1);

    // 5: reset at T0+4 abandons the chunk; restart gives a clean checksum
    load_seq_words();
    start_chunk(20, 1'b0, 2'd1, 64'd0, 1'b0);
    tick(4);
    sys_rst    = 1'b1;
    count_init = 32'd0;
    tick(1);
    sys_rst = 1'b0;
    @(negedge clk);
    check("t5_state0", 64'(st0), 64'(S_IDLE));
    check("t5_state1", 64'(st1), 64'(S_IDLE));
    check("t5_cs0", cs0, 64'd0);
    check("t5_cs1", cs1, 64'd0);
    check("t5_off0", 64'(rd_off0), 64'd0);
    tick(21);
    check_idle_valid("t5_paused", 1'b0);
    start_chunk(20, 1'b0, 2'd1, 64'd36, 1'b1);
    wait_acks();
    check_idle_valid("t5", 1'b1);

    // 6: ring full with zero dwell stalls; nonzero dwell starts at once
    clear_cs();
    count_init = 32'd0;
    wr_ptr     = 2'd0;
    tick(2);
    @(negedge clk);
    check("t6_busy0", 64'(busy0), 64'd0);
    check("t6_valid0", 64'(cs_valid0), 64'd0);
    check("t6_state1", 64'(st1), 64'(S_IDLE));
`ifdef C2F_CONSUMER_STATS_EN
    t_stall = int'(stall_cnt0);
    repeat (5) @(negedge clk);
    check("t6_stall0", 64'(stall_cnt0), 64'(t_stall + 5));
`else
    t_stall = 0;
    repeat (5) @(negedge clk);
    check("t6_paused_state0", 64'(st0), 64'(S_IDLE + t_stall));
`endif
    @(posedge clk);
    #1;
    start_chunk(10, 1'b0, 2'd0, 64'd36, 1'b1);
    @(negedge clk);
    check("t6_t0_off0", 64'(rd_off0), 64'd0);
    tick(1);
    count_init = 32'd0;
    @(negedge clk);
    check("t6_busy_t1_0", 64'(busy0), 64'd1);
    check("t6_busy_t1_1", 64'(busy1), 64'd1);
    wait_acks();
    @(negedge clk);
    check("t6_end_state0", 64'(st0), 64'(S_IDLE));
    check("t6_end_busy1", 64'(busy1), 64'd0);
`ifdef C2F_CONSUMER_STATS_EN
    check("t6_chunks0", 64'(chunk_cnt0), 64'd2);
    check("t6_chunks1", 64'(chunk_cnt1), 64'd2);
`endif
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/c2f_chunk_consumer.md
Name: c2f_chunk_consumer

Overview:
- Parametrised successor to the single-width C2F example consumer.
- Drains one chunk at a time from the C2F chunk RAM and accumulates a checksum (ADD or XOR, chosen per chunk).
- Holds each chunk for a programmable dwell time, then acknowledges it to the tlp_xcvr ring logic.
- Supports any chunk length and any RAM read latency, so it can sit behind pipelined or registered RAMs.

Parameters:
- PTR_WIDTH, 2: chunk pointer width (ring depth 2^PTR_WIDTH).
- OFFSET_WIDTH, 4: log2 of words per chunk; N = 2^OFFSET_WIDTH.
- DATA_WIDTH, 64: RAM word and checksum width.
- RD_LATENCY, 1: cycles from rdOffset_out to valid rdData_in; legal range 1..4.

Ports:
- sysClk_in  in  1  system clock.
- sysRst_in  in  1  synchronous active-high reset.
- wrPtr_in  in  PTR_WIDTH  producer chunk pointer.
- rdPtr_in  in  PTR_WIDTH  consumer chunk pointer, advanced by the ring logic on dtAck_out.
- dtAck_out  out  1  one-cycle chunk-consumed pulse.
- rdOffset_out  out  OFFSET_WIDTH  RAM word address within the current chunk.
- rdData_in  in  DATA_WIDTH  RAM read data.
- mode_in  in  1  checksum mode: 0 = ADD mod 2^DATA_WIDTH, 1 = XOR; sampled at chunk start.
- csData_out  out  DATA_WIDTH  running checksum.
- csValid_out  out  1  ring empty and block idle.
- csReset_in  in  1  clear the checksum.
- countInit_in  in  32  dwell cycles per chunk; 0 = paused.
- busy_out  out  1  block is not in IDLE.

Behaviour:
- Reset values:
  - state IDLE; dtAck_out 0; rdOffset_out 0; csData_out 0; busy_out 0.
  - csValid_out follows its equation: 1 if the pointers are equal.
  - Holdoff flag clear; read-valid pipeline cleared.
- Reset mid-chunk abandons the chunk. No ack is issued and no partial state survives.
- States:
  - IDLE -> READ when countInit_in != 0, wrPtr_in != rdPtr_in and holdoff is clear. This is cycle T0.
  - In cycle T0: rdOffset_out = 0 combinationally; countInit_in and mode_in are latched.
  - READ: rdOffset_out = k in cycle T0+k, for k = 0..N-1. After offset N-1, go to DRAIN.
  - DRAIN: wait until the last word has been accumulated, then go to WAIT.
  - WAIT: count down. In cycle T0+D, go to ACK, where D = max(latched countInit, N + RD_LATENCY).
  - ACK: dtAck_out = 1 for exactly one cycle (cycle T0+D). Then go to IDLE with holdoff set.
  - Holdoff blocks a start for one cycle, so the ring logic can update rdPtr_in.
  - rdOffset_out outside READ/T0 holds its last value (don't-care).
- Read tracking:
  - A RD_LATENCY-deep valid shift register tags each issued offset.
  - The word for offset k is accumulated on the edge ending cycle T0+k+RD_LATENCY.
  - rdData_in is ignored when untagged.
- Checksum update:
  - ADD: ck = (ck + d) truncated to DATA_WIDTH.
  - XOR: ck = ck ^ d.
  - csData_out is registered. The full chunk is therefore reflected no later than the dtAck_out cycle.
- csReset_in:
  - Clears the checksum to 0 on the next edge, in any state.
  - If it coincides with an accumulate, reset wins and that word is dropped.
  - Later words of the same chunk accumulate from 0.
- csValid_out = (wrPtr_in == rdPtr_in) && state == IDLE.
- countInit_in changing mid-chunk has no effect until the next chunk.
- countInit_in = 0 is honoured only at IDLE; a running chunk completes.
- Pointer wrap is natural modulo 2^PTR_WIDTH. Only equality is used, so full and empty are both handled.

Optional Feature:
- Macro C2F_CONSUMER_STATS_EN.
- Defined:
  - Adds port chunkCount_out (out, 32): chunks acked since reset, incremented the cycle after dtAck_out.
  - Adds port stallCount_out (out, 32): cycles spent in IDLE with the ring non-empty but countInit_in = 0.
  - Both counters saturate at 2^32-1 and clear on sysRst_in.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- tlp_xcvr_pkg holds:
  - the C2FChunkPtr and C2FChunkOffset typedefs (parametric width via package localparams), uint32, uint64;
  - the CkMode enum {CK_ADD, CK_XOR};
  - the state enum ConsumerState.
- Sub-module c2f_ck_accum holds the checksum register, mode mux, clear priority and valid-tag shift register. It takes RD_LATENCY and DATA_WIDTH.
- The top level holds the FSM, offset generator and dwell counter.

Test Plan:
Common bench setup: N = 8, RD_LATENCY = 1, ADD mode, RAM words = offset+1, countInit_in = 20, wrPtr_in = 1, rdPtr_in = 0.
1. Common setup -> rdOffset_out 0..7 in T0..T0+7; dtAck_out high only at T0+20; csData_out = 36; csValid_out = 1 once rdPtr_in = 1.
2. Same setup with countInit_in = 3 -> dtAck_out at T0+9, i.e. N+L minimum; checksum 36.
3. XOR mode, words 0xFF,0x0F,0,0,0,0,0,0 -> csData_out = 0xF0; pulse csReset_in afterwards -> 0.
4. RD_LATENCY = 3, ADD, words all 0xFFFF_FFFF_FFFF_FFFF -> checksum 0xFFFF_FFFF_FFFF_FFF8 (wraps); dtAck_out at T0+20.
5. sysRst_in asserted at T0+4 -> no dtAck_out, csData_out = 0, state IDLE; restart gives a clean checksum of 36.
6. Ring full (wrPtr_in = 0, rdPtr_in = 1) with countInit_in = 0 -> no start; stallCount_out increments (STATS_EN); setting countInit_in = 10 starts the next cycle.
